// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle for alu_exec_unit
// Flag signals exist only when ALU_EXEC_FLAGS_EN is defined.
interface alu_exec_unit_if #(
  parameter int WORD_SIZE = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           op;
  logic [WORD_SIZE-1:0] a;
  logic [WORD_SIZE-1:0] b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] result;
`ifdef ALU_EXEC_FLAGS_EN
  logic                 zero;
  logic                 negative;
  logic                 overflow;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result
`ifdef ALU_EXEC_FLAGS_EN
    , input zero, negative, overflow
`endif
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result
`ifdef ALU_EXEC_FLAGS_EN
    , output zero, negative, overflow
`endif
  );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU executor with chunk-serial add/sub
// Optional zero/negative/overflow flags are built when ALU_EXEC_FLAGS_EN is defined.
module alu_exec_unit #(
  parameter int WORD_SIZE = 16,
  parameter int CHUNK     = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);
  localparam int N    = WORD_SIZE / CHUNK;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int HALF = WORD_SIZE / 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q;
  logic [3:0]           op_q;
  logic [WORD_SIZE-1:0] a_q, b_q, result_q;
  logic [CW-1:0]        cnt_q;
  logic                 carry_q;
  logic                 in_ready_q, out_valid_q;

  logic                 is_arith;
  logic [WORD_SIZE-1:0] b_eff;
  logic [CHUNK:0]       sum_d;
  logic [WORD_SIZE-1:0] res_d;
  logic                 finish_d;
  logic                 ovf_d;

  always_comb begin
    is_arith = (op_q == 4'h0) || (op_q == 4'h1);
    b_eff    = (op_q == 4'h1) ? ~b_q : b_q;
    sum_d    = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} + {1'b0, b_eff[cnt_q*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};
    finish_d = !is_arith || (cnt_q == CW'(N - 1));
    res_d    = result_q;
    if (is_arith) begin
      res_d[cnt_q*CHUNK +: CHUNK] = sum_d[CHUNK-1:0];
    end else begin
      case (op_q)
        4'h5:    res_d = a_q & b_q;
        4'h6:    res_d = a_q | b_q;
        4'h9:    res_d = ~a_q;
        4'hA:    res_d = {a_q[WORD_SIZE-1], a_q[WORD_SIZE-1:1]};
        4'hC:    res_d = ~a_q + WORD_SIZE'(1);
        4'hD:    res_d = {a_q[WORD_SIZE-2:0], 1'b0};
        4'hF:    res_d = b_q << (WORD_SIZE - HALF);
        default: res_d = '0;
      endcase
    end
    // Only meaningful on the final chunk, when res_d holds the complete sum
    ovf_d = is_arith && (a_q[WORD_SIZE-1] == b_eff[WORD_SIZE-1])
                     && (res_d[WORD_SIZE-1] != a_q[WORD_SIZE-1]);
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic zero_q, negative_q, overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state_q == S_BUSY && finish_d) begin
      zero_q     <= (res_d == '0);
      negative_q <= res_d[WORD_SIZE-1];
      overflow_q <= ovf_d;
    end
  end

  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
  assign bus.overflow = overflow_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            a_q        <= bus.a;
            b_q        <= bus.b;
            cnt_q      <= '0;
            carry_q    <= (bus.op == 4'h1);
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          result_q <= res_d;
          if (is_arith) begin
            carry_q <= sum_d[CHUNK];
            cnt_q   <= cnt_q + CW'(1);
          end
          if (finish_d) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit
// Flag checks are compiled in when ALU_EXEC_FLAGS_EN is defined.
module tb_alu_exec_unit;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int N  = W / CH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [W-1:0] got_res;
  int           got_lat;
  logic         got_z, got_n, got_v;

  alu_exec_unit_if #(.WORD_SIZE(W)) bus ();
  alu_exec_unit #(.WORD_SIZE(W), .CHUNK(CH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    sa = a;
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h5:    return a & b;
      4'h6:    return a | b;
      4'h9:    return ~a;
      4'hA:    return sa >>> 1;
      4'hC:    return 16'd0 - a;
      4'hD:    return a << 1;
      4'hF:    return {b[7:0], 8'h00};
      default: return '0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    if (op == 4'h0)      s = int'($signed(a)) + int'($signed(b));
    else if (op == 4'h1) s = int'($signed(a)) - int'($signed(b));
    else                 return 1'b0;
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (op == 4'h0 || op == 4'h1) ? N : 1;
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
  endtask

  // Issues one op from IDLE, scrambles inputs after acceptance, captures result and consumes it
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
    got_lat = 0;
    while (!bus.out_valid && got_lat < 40) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_res = bus.result;
`ifdef ALU_EXEC_FLAGS_EN
    got_z = bus.zero; got_n = bus.negative; got_v = bus.overflow;
`else
    got_z = 1'b0; got_n = 1'b0; got_v = 1'b0;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    exp = model(op, a, b);
    run_op(op, a, b);
    checks++;
    if (got_res !== exp) begin
      failures++;
      $display("FAIL %s result: op=%h a=%h b=%h got %h expected %h", name, op, a, b, got_res, exp);
    end
    checks++;
    if (got_lat !== model_lat(op)) begin
      failures++;
      $display("FAIL %s latency: op=%h got %0d expected %0d", name, op, got_lat, model_lat(op));
    end
`ifdef ALU_EXEC_FLAGS_EN
    checks++;
    if ({got_z, got_n, got_v} !== {exp == '0, exp[W-1], model_ovf(op, a, b)}) begin
      failures++;
      $display("FAIL %s flags zno: op=%h a=%h b=%h got %b expected %b", name, op, a, b,
               {got_z, got_n, got_v}, {exp == '0, exp[W-1], model_ovf(op, a, b)});
    end
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset handshake: got in_ready/out_valid %b expected 10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if (bus.result !== 16'h0000) begin
      failures++;
      $display("FAIL reset result: got %h expected 0000", bus.result);
    end
`ifdef ALU_EXEC_FLAGS_EN
    checks++;
    if ({bus.zero, bus.negative, bus.overflow} !== 3'b000) begin
      failures++;
      $display("FAIL reset flags: got %b expected 000", {bus.zero, bus.negative, bus.overflow});
    end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    check_op("add_7fff_1", 4'h0, 16'h7FFF, 16'h0001);
    check_op("sub_5_7", 4'h1, 16'h0005, 16'h0007);
    check_op("sub_equal", 4'h1, 16'h1234, 16'h1234);
    check_op("sub_min", 4'h1, 16'h0001, 16'h8000);
    for (int i = 0; i < 20; i++)
      check_op("rand_arith", 4'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
  endtask

  task automatic test_single_cycle();
    check_op("shr", 4'hA, 16'h8004, 16'h0000);
    check_op("shl", 4'hD, 16'h8001, 16'h0000);
    check_op("tcp", 4'hC, 16'h0001, 16'h0000);
    check_op("lhi", 4'hF, 16'h1234, 16'h00AB);
    check_op("undef3", 4'h3, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 40; i++)
      check_op("rand_any", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
  endtask

  task automatic test_backpressure();
    int t;
    bus.in_valid = 1'b1; bus.op = 4'h6; bus.a = 16'h00F0; bus.b = 16'h0F00;
    @(posedge clk); #1;
    bus.op = 4'h0; bus.a = 16'h1111; bus.b = 16'h2222;
    t = 0;
    while (!bus.out_valid && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.result, bus.out_valid, bus.in_ready} !== {16'h0FF0, 2'b10}) begin
        failures++;
        $display("FAIL backpressure hold %0d: got result=%h ov=%b ir=%b expected 0ff0 1 0",
                 i, bus.result, bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.result} !== {2'b10, 16'h0FF0}) begin
      failures++;
      $display("FAIL backpressure consume: got ir=%b ov=%b result=%h expected 1 0 0ff0",
               bus.in_ready, bus.out_valid, bus.result);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure no_accept_on_consume: got in_ready %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_reset_abort();
    bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 16'h1234; bus.b = 16'h4321;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b01, 16'h0000}) begin
      failures++;
      $display("FAIL reset_abort: got ov=%b ir=%b result=%h expected 0 1 0000",
               bus.out_valid, bus.in_ready, bus.result);
    end
    check_op("and_after_abort", 4'h5, 16'hFF00, 16'h0FF0);
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops_op [3];
    logic [W-1:0] ops_a [3], ops_b [3];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp;
    int acc [3];
    int idx, got, cyc;
    logic accept;
    for (int i = 0; i < 3; i++) begin
      ops_op[i] = 4'h0; ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom);
    end
    idx = 0; got = 0; cyc = 0;
    bus.op = ops_op[0]; bus.a = ops_a[0]; bus.b = ops_b[0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (got < 3 && cyc < 80) begin
      accept = bus.in_ready && bus.in_valid;
      if (accept) exp_q.push_back(model(bus.op, bus.a, bus.b));
      if (bus.out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (bus.result !== exp) begin
          failures++;
          $display("FAIL b2b result %0d: got %h expected %h", got, bus.result, exp);
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (accept) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          bus.op = ops_op[idx]; bus.a = ops_a[idx]; bus.b = ops_b[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (got !== 3 || idx !== 3) begin
      failures++;
      $display("FAIL b2b count: got results=%0d accepts=%0d expected 3 3", got, idx);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc[i] - acc[i-1] !== N + 2) begin
          failures++;
          $display("FAIL b2b spacing %0d: got %0d cycles expected %0d", i, acc[i] - acc[i-1], N + 2);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_single_cycle();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
